elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
Sequencing controller for the 4-floor elevator car. It latches cab and hall calls into a pending mask and picks the next floor with a SCAN (continue-in-direction) policy. It paces floor-to-floor travel and door dwell with counters, and handles the emergency key. Its cur_floor, door_open and direction outputs feed the existing floor display, door LED and floor LED logic.

Parameters:
NUM_FLOORS, 4, number of floors; legal range 2..16; floor index width FW = $clog2(NUM_FLOORS)
TRAVEL_CYCLES, 8, clock cycles per one-floor move; must be >= 1
DOOR_CYCLES, 4, clock cycles the door stays open per stop; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cab_req  input  NUM_FLOORS  in-car floor buttons, one bit per floor, level or pulse
hall_up  input  NUM_FLOORS  hall UP buttons, one bit per floor
hall_dn  input  NUM_FLOORS  hall DOWN buttons, one bit per floor
emer  input  1  emergency key, level
cur_floor  output  FW  floor the car is at, or the last floor it passed
pending  output  NUM_FLOORS  latched outstanding calls
moving_up  output  1  car travelling up
moving_dn  output  1  car travelling down
door_open  output  1  door open / door LED
emergency  output  1  high while in the EMER state

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: cur_floor=0, pending=0, every output 0, state=IDLE, dir=UP, both counters 0.
- Request capture: each edge, pending |= (cab_req | hall_up | hall_dn).
  - Requests are ignored in EMER.
  - Requests are ignored for cur_floor while in DOOR.
  - If a request sets a bit on the same edge that bit is cleared, clear wins.
- The FSM decides from registered pending, so there is 1 cycle of latency from a request to leaving IDLE.
- dir register: holds UP or DOWN.
  - "above" = any pending bit with index > cur_floor.
  - "below" = any pending bit with index < cur_floor.
- State IDLE:
  - emer -> EMER.
  - pending[cur_floor] -> DOOR, and clear that bit.
  - Otherwise, if there is a call in dir -> MOVE in dir.
  - Otherwise, if there is a call in the opposite direction -> flip dir, then MOVE.
  - Otherwise stay in IDLE.
- State MOVE:
  - moving_up = (dir==UP), moving_dn = (dir==DOWN).
  - trav_cnt increments every cycle.
  - On the edge where trav_cnt==TRAVEL_CYCLES-1: trav_cnt<=0 and cur_floor steps by +/-1.
  - Arrival at the new floor f (decided on that same edge):
    - emer latched -> EMER.
    - pending[f] -> DOOR, clear pending[f].
    - No call further in dir -> DOOR (cannot happen with a consistent mask; treat as a safe stop).
    - Otherwise stay in MOVE.
  - cur_floor never leaves the range 0..NUM_FLOORS-1. Reaching an end floor forces DOOR or IDLE; there is no wrap-around.
  - emer asserted mid-segment is latched. The car finishes the current segment, then goes to EMER. It never stops between floors.
- State DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, counted by door_cnt.
  - Then IDLE, with door_cnt cleared.
  - emer -> EMER immediately.
- State EMER:
  - emergency=1, door_open=1, moving_* = 0.
  - pending is cleared on entry and held at 0.
  - emer deasserted -> DOOR, with a full DOOR_CYCLES dwell.
- All outputs are registered; they reflect the new state in the cycle after each transition.
- Reset asserted mid-operation returns everything to the reset values immediately, including cur_floor=0 (the car is re-homed).

Optional Feature:
- Macro ELEVATOR_DOOR_HOLD_EN.
- Defined: adds input port door_hold (1 bit).
  - While door_hold=1 in DOOR, door_cnt is held at 0, so the door stays open.
  - After release, the full DOOR_CYCLES dwell still follows.
  - door_hold has no effect in any other state.
- Not defined: the port is absent and the dwell is always exactly DOOR_CYCLES.

Test Plan:
- Reset: assert rst_n=0 mid-MOVE at floor 2 -> immediately cur_floor=0, pending=0, door_open=0, moving_up=0, emergency=0.
- Single call (defaults, car IDLE at floor 0): cab_req=4'b0100 pulsed 1 cycle -> pending=0100; moving_up rises 2 edges later; cur_floor=1 after 8 MOVE cycles, 2 after 16; pending=0; door_open high 4 cycles; then IDLE.
- SCAN stop-along-the-way: car moving up 0->3; hall_dn[2] pulsed while cur_floor=1 -> car stops at 2 (door 4 cycles), then continues to 3; pending=0 at end.
- Same-floor call: IDLE at floor 1, hall_up=4'b0010 -> door_open=1 within 2 cycles for 4 cycles; moving_up and moving_dn never assert.
- Direction preference: IDLE at floor 1 with dir=UP, calls at floors 0 and 3 set on the same edge -> car goes up to 3 first, then down to 0.
- Emergency mid-travel: emer=1 halfway between floors 1 and 2 going up -> cur_floor reaches 2, then emergency=1, door_open=1, pending=0; cab_req ignored while emer=1; emer=0 -> 4-cycle door dwell, then IDLE.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Sequencing controller for a small elevator car. Cab and hall calls are
// latched into a pending mask. The next stop is chosen with a SCAN policy:
// the car keeps going in its current direction while calls remain ahead of
// it, and reverses only when nothing is left that way. Counters pace
// floor-to-floor travel and door dwell. An emergency key parks the car with
// the door open and discards all outstanding calls.
//
// Optional feature (compile-time macro ELEVATOR_DOOR_HOLD_EN):
//   Adds input door_hold. While it is high in DOOR, the dwell counter is held
//   at zero, so the door stays open. A full dwell follows the release.
//
// Parameters:
//   NUM_FLOORS     number of floors (2..16)
//   TRAVEL_CYCLES  clock cycles per one-floor move (>= 1)
//   DOOR_CYCLES    clock cycles the door stays open per stop (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (re-homes the car to floor 0)
//   door_hold  in   keep door open while high (only with ELEVATOR_DOOR_HOLD_EN)
//   cab_req    in   in-car floor buttons, one bit per floor
//   hall_up    in   hall UP buttons, one bit per floor
//   hall_dn    in   hall DOWN buttons, one bit per floor
//   emer       in   emergency key, level
//   cur_floor  out  floor the car is at, or the last floor it passed
//   pending    out  latched outstanding calls
//   moving_up  out  car travelling up
//   moving_dn  out  car travelling down
//   door_open  out  door open / door LED
//   emergency  out  high while parked in the emergency state
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  localparam int FW           = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [NUM_FLOORS-1:0] cab_req,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic                  emer,
  output logic [FW-1:0]         cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_dn,
  output logic                  door_open,
  output logic                  emergency
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR,
    S_EMER
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  // Registered state
  state_t                r_state;
  dir_t                  r_dir;
  logic [FW-1:0]         r_cur_floor;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [TW-1:0]         r_trav_cnt;
  logic [DW-1:0]         r_door_cnt;
  logic                  r_emer_lat;   // emergency seen mid-segment
  logic                  r_moving_up;
  logic                  r_moving_dn;
  logic                  r_door_open;
  logic                  r_emergency;

  // Next-state and helper signals
  state_t                w_state_nxt;
  dir_t                  w_dir_nxt;
  logic [FW-1:0]         w_floor_nxt;
  logic [TW-1:0]         w_trav_nxt;
  logic [DW-1:0]         w_door_nxt;
  logic                  w_emer_lat_nxt;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_req;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic                  w_above;
  logic                  w_below;
  logic                  w_further;    // call beyond the arrival floor, in dir
  logic                  w_call_in_dir;
  logic                  w_can_step;
  logic [FW-1:0]         w_arr_floor;
  logic                  w_hold;

  function automatic logic [NUM_FLOORS-1:0] f_onehot(input logic [FW-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign w_hold = door_hold;
`else
  assign w_hold = 1'b0;
`endif

  // An end floor is never stepped past, even with an inconsistent mask.
  assign w_can_step  = (r_dir == DIR_UP) ? (r_cur_floor != FW'(NUM_FLOORS - 1))
                                         : (r_cur_floor != '0);
  assign w_arr_floor = !w_can_step       ? r_cur_floor :
                       (r_dir == DIR_UP) ? r_cur_floor + FW'(1)
                                         : r_cur_floor - FW'(1);

  // Where the outstanding calls lie relative to the car.
  always_comb begin
    w_above   = 1'b0;
    w_below   = 1'b0;
    w_further = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(r_cur_floor)) w_above = w_above | r_pending[i];
      if (i < int'(r_cur_floor)) w_below = w_below | r_pending[i];
      if ((r_dir == DIR_UP && i > int'(w_arr_floor)) ||
          (r_dir == DIR_DN && i < int'(w_arr_floor)))
        w_further = w_further | r_pending[i];
    end
  end

  assign w_call_in_dir = (r_dir == DIR_UP) ? w_above : w_below;

  // Sequencing decisions.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_floor_nxt    = r_cur_floor;
    w_trav_nxt     = r_trav_cnt;
    w_door_nxt     = r_door_cnt;
    w_emer_lat_nxt = r_emer_lat;
    w_clr          = '0;

    unique case (r_state)
      S_IDLE: begin
        w_trav_nxt = '0;
        w_door_nxt = '0;
        if (emer) begin
          w_state_nxt = S_EMER;
        end else if (r_pending[r_cur_floor]) begin
          w_state_nxt = S_DOOR;
          w_clr       = f_onehot(r_cur_floor);
        end else if (w_call_in_dir) begin
          w_state_nxt = S_MOVE;
        end else if (w_above || w_below) begin
          w_dir_nxt   = (r_dir == DIR_UP) ? DIR_DN : DIR_UP;
          w_state_nxt = S_MOVE;
        end
      end

      S_MOVE: begin
        // The car never stops between floors; a key press is remembered
        // until the segment completes.
        if (emer) w_emer_lat_nxt = 1'b1;
        if (r_trav_cnt == TW'(TRAVEL_CYCLES - 1)) begin
          w_trav_nxt  = '0;
          w_floor_nxt = w_arr_floor;
          if (r_emer_lat || emer) begin
            w_state_nxt    = S_EMER;
            w_emer_lat_nxt = 1'b0;
          end else if (r_pending[w_arr_floor]) begin
            w_state_nxt = S_DOOR;
            w_clr       = f_onehot(w_arr_floor);
          end else if (!w_further) begin
            w_state_nxt = S_DOOR;   // safe stop: nothing left ahead
          end
        end else begin
          w_trav_nxt = r_trav_cnt + TW'(1);
        end
      end

      S_DOOR: begin
        if (emer) begin
          w_state_nxt = S_EMER;
          w_door_nxt  = '0;
        end else if (w_hold) begin
          w_door_nxt = '0;
        end else if (r_door_cnt == DW'(DOOR_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_door_nxt  = '0;
        end else begin
          w_door_nxt = r_door_cnt + DW'(1);
        end
      end

      S_EMER: begin
        w_trav_nxt = '0;
        w_door_nxt = '0;
        if (!emer) w_state_nxt = S_DOOR;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Call capture: nothing is accepted in EMER, and a call for the floor whose
  // door is open is already being served. A clear on the same edge wins.
  always_comb begin
    w_req = cab_req | hall_up | hall_dn;
    if (r_state == S_DOOR) w_req = w_req & ~f_onehot(r_cur_floor);
    if (r_state == S_EMER) w_req = '0;
    w_pending_nxt = (w_state_nxt == S_EMER) ? '0 : ((r_pending | w_req) & ~w_clr);
  end

  // Single state register; outputs are registered from the next state so they
  // reflect a transition in the cycle after it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dir       <= DIR_UP;
      r_cur_floor <= '0;
      r_pending   <= '0;
      r_trav_cnt  <= '0;
      r_door_cnt  <= '0;
      r_emer_lat  <= 1'b0;
      r_moving_up <= 1'b0;
      r_moving_dn <= 1'b0;
      r_door_open <= 1'b0;
      r_emergency <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_cur_floor <= w_floor_nxt;
      r_pending   <= w_pending_nxt;
      r_trav_cnt  <= w_trav_nxt;
      r_door_cnt  <= w_door_nxt;
      r_emer_lat  <= w_emer_lat_nxt;
      r_moving_up <= (w_state_nxt == S_MOVE) && (w_dir_nxt == DIR_UP);
      r_moving_dn <= (w_state_nxt == S_MOVE) && (w_dir_nxt == DIR_DN);
      r_door_open <= (w_state_nxt == S_DOOR) || (w_state_nxt == S_EMER);
      r_emergency <= (w_state_nxt == S_EMER);
    end
  end

  assign cur_floor = r_cur_floor;
  assign pending   = r_pending;
  assign moving_up = r_moving_up;
  assign moving_dn = r_moving_dn;
  assign door_open = r_door_open;
  assign emergency = r_emergency;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_call_scheduler
//
// Self-checking bench for elevator_call_scheduler with default parameters
// (4 floors, 8 travel cycles, 4 door cycles). A table of call patterns is
// applied from a known car position; the floors where the door is expected
// to open are queued when the calls are driven, and a monitor pops and
// compares them each time the door opens. Hand-written sequences cover exact
// timing, stopping along the way, emergency, same-floor calls and reset.
// -----------------------------------------------------------------------------
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cab_req = '0;
  logic [3:0] hall_up = '0;
  logic [3:0] hall_dn = '0;
  logic       emer = 1'b0;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic [1:0] cur_floor;
  logic [3:0] pending;
  logic       moving_up;
  logic       moving_dn;
  logic       door_open;
  logic       emergency;

  elevator_call_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .cab_req   (cab_req),
    .hall_up   (hall_up),
    .hall_dn   (hall_dn),
    .emer      (emer),
    .cur_floor (cur_floor),
    .pending   (pending),
    .moving_up (moving_up),
    .moving_dn (moving_dn),
    .door_open (door_open),
    .emergency (emergency)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sb_q[$];          // expected door-stop floors, in order
  logic door_prev = 1'b0;
  logic watch_motion = 1'b0;
  logic saw_motion = 1'b0;
  int   sb_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic car_idle();
    return (pending == 4'b0) && !moving_up && !moving_dn && !door_open && !emergency;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!car_idle() && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(car_idle()), 1);
  endtask

  // Counts door-open cycles starting from a cycle already sampled open.
  task automatic count_dwell(input string name, input int exp_cycles);
    int n = 1;
    tick();
    while (door_open && n < 40) begin
      n++;
      tick();
    end
    check(name, n, exp_cycles);
  endtask

  // Stop monitor: each new door opening (outside emergency) must match the
  // next queued floor.
  always @(posedge clk) begin
    #1;
    if (rst_n && door_open && !door_prev && !emergency) begin
      if (sb_q.size() > 0) begin
        sb_exp = sb_q.pop_front();
        check("sb_stop_floor", 32'(cur_floor), sb_exp);
      end else begin
        n_checks++;
        $display("FAIL sb_stop: unexpected stop at floor %0d, none expected", cur_floor);
      end
    end
    if (watch_motion && (moving_up || moving_dn)) saw_motion = 1'b1;
    door_prev = door_open;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] cab;
    logic [3:0] hup;
    logic [3:0] hdn;
    int         n_stops;
    int         s0, s1, s2, s3;
    int         fin;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Chained from reset: floor 0, direction UP.
    vecs[0] = '{4'b0100, 4'b0000, 4'b0000, 1, 2, 0, 0, 0, 2}; // up to 2
    vecs[1] = '{4'b1000, 4'b0010, 4'b0000, 2, 3, 1, 0, 0, 1}; // up first, then down
    vecs[2] = '{4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 0}; // down to 0
    vecs[3] = '{4'b0010, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 1}; // reversal at 0
    vecs[4] = '{4'b0001, 4'b0000, 4'b1000, 2, 3, 0, 0, 0, 0}; // dir UP preference
    vecs[5] = '{4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 0}; // same floor
    vecs[6] = '{4'b1111, 4'b0000, 4'b0000, 4, 0, 1, 2, 3, 3}; // sweep up
    vecs[7] = '{4'b0000, 4'b0000, 4'b0101, 2, 2, 0, 0, 0, 0}; // sweep down

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_cur_floor", 32'(cur_floor), 0);
    check("rst_pending",   32'(pending),   0);
    check("rst_moving_up", 32'(moving_up), 0);
    check("rst_moving_dn", 32'(moving_dn), 0);
    check("rst_door_open", 32'(door_open), 0);
    check("rst_emergency", 32'(emergency), 0);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven call patterns ----------------
    for (int i = 0; i < 8; i++) begin
      cab_req = vecs[i].cab;
      hall_up = vecs[i].hup;
      hall_dn = vecs[i].hdn;
      if (vecs[i].n_stops > 0) sb_q.push_back(vecs[i].s0);
      if (vecs[i].n_stops > 1) sb_q.push_back(vecs[i].s1);
      if (vecs[i].n_stops > 2) sb_q.push_back(vecs[i].s2);
      if (vecs[i].n_stops > 3) sb_q.push_back(vecs[i].s3);
      tick();
      cab_req = '0;
      hall_up = '0;
      hall_dn = '0;
      wait_idle($sformatf("vec%0d", i), 300);
      check($sformatf("vec%0d_final_floor", i), 32'(cur_floor), vecs[i].fin);
      check($sformatf("vec%0d_queue_empty", i), sb_q.size(), 0);
    end

    // ---------------- single call, exact timing (floor 0 -> 2) ----------------
    cab_req = 4'b0100;
    sb_q.push_back(2);
    tick();
    cab_req = '0;
    check("single_pending_latched", 32'(pending), 4'b0100);
    check("single_not_moving_yet",  32'(moving_up), 0);
    tick();
    check("single_moving_up",       32'(moving_up), 1);
    repeat (7) tick();
    check("single_floor0_at_7",     32'(cur_floor), 0);
    tick();
    check("single_floor1_at_8",     32'(cur_floor), 1);
    repeat (8) tick();
    check("single_floor2_at_16",    32'(cur_floor), 2);
    check("single_door_open",       32'(door_open), 1);
    check("single_pending_clear",   32'(pending), 0);
    check("single_stopped",         32'(moving_up), 0);
    count_dwell("single_dwell", 4);
    check("single_idle",            32'(car_idle()), 1);

    // ---------------- SCAN stop along the way ----------------
    cab_req = 4'b0001;
    sb_q.push_back(0);
    tick();
    cab_req = '0;
    wait_idle("scan_home", 200);
    cab_req = 4'b1000;
    sb_q.push_back(2);
    sb_q.push_back(3);
    tick();
    cab_req = '0;
    begin
      int n = 0;
      while (cur_floor != 2'd1 && n < 50) begin
        tick();
        n++;
      end
      check("scan_reach_floor1", 32'(cur_floor), 1);
    end
    check("scan_still_moving", 32'(moving_up), 1);
    hall_dn = 4'b0100;
    tick();
    hall_dn = '0;
    wait_idle("scan", 200);
    check("scan_final_floor", 32'(cur_floor), 3);

    // ---------------- emergency mid-travel 1 -> 2 ----------------
    cab_req = 4'b0010;
    sb_q.push_back(1);
    tick();
    cab_req = '0;
    wait_idle("emer_setup", 200);
    cab_req = 4'b1000;
    tick();
    cab_req = '0;
    tick();
    check("emer_moving_up", 32'(moving_up), 1);
    repeat (4) tick();
    emer = 1'b1;
    begin
      int n = 0;
      while (!emergency && n < 20) begin
        tick();
        n++;
      end
      check("emer_entered", 32'(emergency), 1);
    end
    check("emer_floor",       32'(cur_floor), 2);
    check("emer_door_open",   32'(door_open), 1);
    check("emer_pending_clr", 32'(pending), 0);
    check("emer_not_moving",  32'(moving_up | moving_dn), 0);
    cab_req = 4'b0001;
    tick();
    cab_req = '0;
    check("emer_req_ignored", 32'(pending), 0);
    repeat (3) tick();
    check("emer_held", 32'(emergency), 1);
    emer = 1'b0;
    tick();
    check("emer_exit_flag", 32'(emergency), 0);
    check("emer_exit_door", 32'(door_open), 1);
    count_dwell("emer_exit_dwell", 4);
    wait_idle("emer_exit", 50);
    check("emer_final_floor", 32'(cur_floor), 2);

    // ---------------- same-floor call ----------------
    hall_up = 4'b0100;
    sb_q.push_back(2);
    saw_motion = 1'b0;
    watch_motion = 1'b1;
    tick();
    hall_up = '0;
    check("same_door_not_yet", 32'(door_open), 0);
    tick();
    check("same_door_open", 32'(door_open), 1);
    count_dwell("same_dwell", 4);
    wait_idle("same", 50);
    repeat (3) tick();
    watch_motion = 1'b0;
    check("same_no_motion", 32'(saw_motion), 0);

    // ---------------- reset mid-move at floor 2 ----------------
    cab_req = 4'b1000;
    tick();
    cab_req = '0;
    tick();
    check("rst2_moving_up", 32'(moving_up), 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst2_cur_floor", 32'(cur_floor), 0);
    check("rst2_pending",   32'(pending),   0);
    check("rst2_door_open", 32'(door_open), 0);
    check("rst2_moving_up", 32'(moving_up), 0);
    check("rst2_emergency", 32'(emergency), 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst2_stays_idle", 32'(car_idle()), 1);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
